uart_word_sequencer: RTL and testbench
======================================

// Module: uart_word_sequencer
// PURPOSE
//  Sequences 32-bit APB-side words onto the byte-wide UART datapath. TX: accepts a word, issues
//  BYTES_PER_WORD tx_start/tx_byte requests to the transmitter LSB-first, one per tx_done. RX:
//  packs successive receiver bytes (done pulses) into a word, holds it until the bus takes it.
//  Sits between the APB interface FSM and the Receiver/transmitter instances inside Uart.
// PARAMETERS
//  BYTES_PER_WORD  4      bytes per word, 2..4; word width fixed at 32, unused MSBs read 0
//  TX_GAP_CYCLES   0      idle clk cycles between tx_done and next tx_start, 0..255
//  TIMEOUT_CYCLES  1000   RX partial-word timeout in clk cycles, 1..65535 (UART_RX_TIMEOUT_EN only)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   reset, synchronous, active-low
//  tx_word_valid  in   1   word offered for transmit
//  tx_word        in   32  word to transmit
//  tx_word_ready  out  1   sequencer can accept a word
//  tx_start       out  1   1-cycle request to transmitter
//  tx_byte        out  8   byte for transmitter, stable from tx_start until tx_done
//  tx_done        in   1   transmitter finished byte (1-cycle pulse)
//  rx_byte_valid  in   1   receiver done pulse (1 cycle)
//  rx_byte        in   8   received byte, valid with rx_byte_valid
//  rx_word_valid  out  1   assembled word available
//  rx_word        out  32  assembled word, byte0 in [7:0]
//  rx_word_ready  in   1   bus consumes rx_word
//  rx_overrun     out  1   1-cycle pulse: byte dropped while word held
//  rx_timeout     out  1   1-cycle pulse: partial word discarded
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all outputs 0 except tx_word_ready=1; shift regs, counters, FSMs
//   cleared; any in-flight word/byte abandoned, tx_start low from the following cycle.
//  TX FSM T_IDLE/T_START/T_WAIT/T_GAP; all outputs registered:
//   T_IDLE: tx_word_ready=1; valid&ready at edge N latches tx_word, idx=0 -> T_START.
//   T_START: tx_start=1 for exactly one cycle (cycle N+1), tx_byte=shift[7:0] -> T_WAIT.
//   T_WAIT: tx_done ignored outside T_WAIT. On tx_done: shift>>=8, idx++; if idx was
//    BYTES_PER_WORD-1 -> T_IDLE (tx_word_ready=1 next cycle), else -> T_GAP (or T_START if gap 0).
//   T_GAP: count TX_GAP_CYCLES cycles then T_START.
//   tx_word_ready=0 in every state except T_IDLE; no word accepted mid-sequence.
//  RX FSM R_COLLECT/R_HOLD:
//   R_COLLECT: rx_byte_valid writes rx_byte to word[8*idx+:8], idx++; on last byte ->
//    R_HOLD with rx_word_valid=1 next cycle; rx_word stable while valid.
//   R_HOLD: rx_word_valid=1 until rx_word_ready sampled high -> R_COLLECT, idx=0, word cleared.
//    rx_byte_valid in R_HOLD without rx_word_ready: byte dropped, rx_overrun pulses.
//    rx_byte_valid same cycle as rx_word_ready: handshake completes AND byte stored as byte0.
//  TX and RX paths fully independent; simultaneous activity legal.
//  idx width $clog2(BYTES_PER_WORD); wraps never occur (FSM returns before overflow).
// CONFIGURATION
//  UART_RX_TIMEOUT_EN defined: 16-bit counter runs in R_COLLECT while idx>0, cleared by every
//   rx_byte_valid; on reaching TIMEOUT_CYCLES: idx=0, word cleared, rx_timeout pulses 1 cycle.
//   Byte arriving in the same cycle the count is reached wins: stored, counter cleared, no timeout.
//  Not defined: no counter; partial word held indefinitely; rx_timeout tied 0.
// TESTING
//  T1 tx_word=32'hA1B2C3D4 valid 1 cycle -> tx_start pulses with tx_byte D4,C3,B2,A1, each after
//     prior tx_done; tx_word_ready=0 throughout, 1 the cycle after 4th tx_done.
//  T2 TX_GAP_CYCLES=3 -> exactly 3 idle cycles between tx_done and next tx_start; stray tx_done
//     during T_GAP ignored (still 4 tx_start total).
//  T3 rx bytes 11,22,33,44 -> rx_word_valid, rx_word=32'h44332211; held 10 cycles with ready=0;
//     5th byte meanwhile -> rx_overrun pulse, rx_word unchanged.
//  T4 ready and byte 55 same cycle in R_HOLD -> handshake done, next word byte0=55 (after 3 more
//     bytes 66,77,88 rx_word=32'h88776655).
//  T5 UART_RX_TIMEOUT_EN, TIMEOUT_CYCLES=20: 2 bytes then silence -> rx_timeout at 20th cycle,
//     next 4 bytes form a clean word; byte on exact 20th cycle -> no timeout. Without macro: no pulse.
//  T6 rst_n low during T_WAIT after byte 2 and with partial RX word -> all outputs reset values,
//     tx_word_ready=1, next word transmits from byte0.

Source files
------------

// File: rtl/uart_word_sequencer.sv
// Word sequencer between the APB side and the byte-wide UART transmitter/receiver.
// Optional RX partial-word timeout: define UART_RX_TIMEOUT_EN.
module uart_word_sequencer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TX_GAP_CYCLES  = 0,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_word_valid,
  input  logic [31:0] tx_word,
  output logic        tx_word_ready,
  output logic        tx_start,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte,
  output logic        rx_word_valid,
  output logic [31:0] rx_word,
  input  logic        rx_word_ready,
  output logic        rx_overrun,
  output logic        rx_timeout
);

  localparam int IDXW = $clog2(BYTES_PER_WORD);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES_PER_WORD - 1);
  localparam logic [7:0] GAP_LAST = 8'((TX_GAP_CYCLES > 0) ? TX_GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {T_IDLE, T_START, T_WAIT, T_GAP} tx_state_t;
  typedef enum logic {R_COLLECT, R_HOLD} rx_state_t;

  tx_state_t       tx_state;
  logic [31:0]     tx_shift;
  logic [IDXW-1:0] tx_idx;
  logic [7:0]      gap_cnt;
  rx_state_t       rx_state;
  logic [IDXW-1:0] rx_idx;
  logic            rx_tmo_hit;

  // tx_byte always shows shift[7:0] of the byte being requested; it only changes when tx_start is raised.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state      <= T_IDLE;
      tx_shift      <= '0;
      tx_idx        <= '0;
      gap_cnt       <= '0;
      tx_word_ready <= 1'b1;
      tx_start      <= 1'b0;
      tx_byte       <= '0;
    end else begin
      tx_start <= 1'b0;
      case (tx_state)
        T_IDLE: begin
          if (tx_word_valid && tx_word_ready) begin
            tx_shift      <= tx_word;
            tx_idx        <= '0;
            tx_byte       <= tx_word[7:0];
            tx_start      <= 1'b1;
            tx_word_ready <= 1'b0;
            tx_state      <= T_START;
          end
        end
        T_START: tx_state <= T_WAIT;
        T_WAIT: begin
          if (tx_done) begin
            tx_shift <= tx_shift >> 8;
            if (tx_idx == LAST_IDX) begin
              tx_word_ready <= 1'b1;
              tx_state      <= T_IDLE;
            end else begin
              tx_idx <= tx_idx + 1'b1;
              if (TX_GAP_CYCLES == 0) begin
                tx_byte  <= tx_shift[15:8];
                tx_start <= 1'b1;
                tx_state <= T_START;
              end else begin
                gap_cnt  <= '0;
                tx_state <= T_GAP;
              end
            end
          end
        end
        T_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            tx_byte  <= tx_shift[7:0];
            tx_start <= 1'b1;
            tx_state <= T_START;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // A byte arriving on the handshake cycle starts the next word instead of being dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state      <= R_COLLECT;
      rx_idx        <= '0;
      rx_word       <= '0;
      rx_word_valid <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      case (rx_state)
        R_COLLECT: begin
          if (rx_byte_valid) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
              if (rx_idx == IDXW'(b)) rx_word[8*b +: 8] <= rx_byte;
            end
            if (rx_idx == LAST_IDX) begin
              rx_idx        <= '0;
              rx_word_valid <= 1'b1;
              rx_state      <= R_HOLD;
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else if (rx_tmo_hit) begin
            rx_idx  <= '0;
            rx_word <= '0;
          end
        end
        R_HOLD: begin
          if (rx_word_ready) begin
            rx_word_valid <= 1'b0;
            rx_state      <= R_COLLECT;
            rx_word       <= {24'h000000, rx_byte_valid ? rx_byte : 8'h00};
            rx_idx        <= rx_byte_valid ? IDXW'(1) : '0;
          end else if (rx_byte_valid) begin
            rx_overrun <= 1'b1;
          end
        end
        default: rx_state <= R_COLLECT;
      endcase
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  // Counter only runs while a partial word sits in R_COLLECT; an arriving byte always beats the timeout.
  assign rx_tmo_hit = (rx_state == R_COLLECT) && (rx_idx != '0) && !rx_byte_valid &&
                      (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt    <= '0;
      rx_timeout <= 1'b0;
    end else begin
      rx_timeout <= rx_tmo_hit;
      if (rx_state != R_COLLECT || rx_idx == '0 || rx_byte_valid || rx_tmo_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign rx_tmo_hit = 1'b0;
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_sequencer.sv
// Bench for uart_word_sequencer: a 4-byte/no-gap and a 3-byte/3-cycle-gap instance checked each cycle
// against a cycle-stamped transaction model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_uart_word_sequencer;

  localparam int TMO = 20;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, tx_word_valid, rx_byte_valid, rx_word_ready;
  logic [31:0] tx_word;
  logic [7:0]  rx_byte;
  logic        tx_done [2];
  logic        tx_word_ready [2], tx_start [2], rx_word_valid [2], rx_overrun [2], rx_timeout [2];
  logic [7:0]  tx_byte [2];
  logic [31:0] rx_word [2];

  uart_word_sequencer #(.BYTES_PER_WORD(4), .TX_GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .tx_word_valid(tx_word_valid), .tx_word(tx_word), .tx_word_ready(tx_word_ready[0]),
    .tx_start(tx_start[0]), .tx_byte(tx_byte[0]), .tx_done(tx_done[0]),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_word_valid(rx_word_valid[0]),
    .rx_word(rx_word[0]), .rx_word_ready(rx_word_ready), .rx_overrun(rx_overrun[0]),
    .rx_timeout(rx_timeout[0]));

  uart_word_sequencer #(.BYTES_PER_WORD(3), .TX_GAP_CYCLES(3), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .tx_word_valid(tx_word_valid), .tx_word(tx_word), .tx_word_ready(tx_word_ready[1]),
    .tx_start(tx_start[1]), .tx_byte(tx_byte[1]), .tx_done(tx_done[1]),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .rx_word_valid(rx_word_valid[1]),
    .rx_word(rx_word[1]), .rx_word_ready(rx_word_ready), .rx_overrun(rx_overrun[1]),
    .rx_timeout(rx_timeout[1]));

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  longint      cyc = 0;
  bit          model_ok = 1'b0;
  bit          m_busy [2], m_wait [2];
  int          m_sent [2];
  longint      m_due [2];
  logic [31:0] m_word [2];
  logic [7:0]  r_bytes [2][4];
  int          r_cnt [2];
  bit          r_hold [2];
  logic [31:0] r_held [2];
  longint      r_last [2];
  bit          e_ready [2], e_start [2], e_rvalid [2], e_ovr [2], e_tmo [2];
  logic [7:0]  e_byte [2];
  logic [31:0] e_rword [2];

  int          dcount [2];
  bit          stray_en = 1'b0;
  logic [7:0]  cap0 [$];
  logic [7:0]  cap1 [$];
  int          ovr_seen [2];
  int          tmo_seen [2];
  logic [7:0]  t1_exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
  logic [7:0]  t6_exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};

  function automatic int bpw(int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int gapOf(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] packRx(int k, int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w = w | (32'(r_bytes[k][i]) << (8 * i));
    return w;
  endfunction

  task automatic checkOutput(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d cycle=%0d actual=%h required=%h", name, k, cyc, act, exp);
    end
  endtask

  // Model: derives each cycle's outputs from event timestamps (accept, done, last byte).
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_busy[k] = 0; m_wait[k] = 0; m_sent[k] = 0; m_due[k] = -1; m_word[k] = '0;
        r_cnt[k] = 0; r_hold[k] = 0; r_held[k] = '0; r_last[k] = 0;
        e_ready[k] = 1; e_start[k] = 0; e_byte[k] = '0;
        e_rvalid[k] = 0; e_rword[k] = '0; e_ovr[k] = 0; e_tmo[k] = 0;
      end else begin
        bit acc;
        acc = !m_busy[k] && (tx_word_valid === 1'b1);
        if (m_wait[k] && tx_done[k] === 1'b1) begin
          m_wait[k] = 0;
          m_sent[k]++;
          if (m_sent[k] == bpw(k)) m_busy[k] = 0;
          else m_due[k] = cyc + 1 + gapOf(k);
        end
        if (m_due[k] == cyc) m_wait[k] = 1;
        if (acc) begin
          m_busy[k] = 1; m_word[k] = tx_word; m_sent[k] = 0; m_due[k] = cyc + 1;
        end
        e_ready[k] = !m_busy[k];
        e_start[k] = (m_due[k] == cyc + 1);
        if (e_start[k]) e_byte[k] = 8'(m_word[k] >> (8 * m_sent[k]));

        e_ovr[k] = 0;
        e_tmo[k] = 0;
        if (r_hold[k]) begin
          if (rx_word_ready === 1'b1) begin
            r_hold[k] = 0;
            r_cnt[k] = 0;
            if (rx_byte_valid === 1'b1) begin
              r_bytes[k][0] = rx_byte; r_cnt[k] = 1; r_last[k] = cyc;
            end
          end else if (rx_byte_valid === 1'b1) begin
            e_ovr[k] = 1;
          end
        end else if (rx_byte_valid === 1'b1) begin
          r_bytes[k][r_cnt[k]] = rx_byte;
          r_cnt[k]++;
          r_last[k] = cyc;
          if (r_cnt[k] == bpw(k)) begin
            r_held[k] = packRx(k, r_cnt[k]); r_hold[k] = 1; r_cnt[k] = 0;
          end
        end else if (TMO_EN && r_cnt[k] > 0 && (cyc - r_last[k]) == TMO) begin
          r_cnt[k] = 0;
          e_tmo[k] = 1;
        end
        e_rvalid[k] = r_hold[k];
        e_rword[k] = r_hold[k] ? r_held[k] : packRx(k, r_cnt[k]);
      end
    end
    if (!rst_n) model_ok = 1'b1;
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        checkOutput("tx_word_ready", k, 32'(tx_word_ready[k]), 32'(e_ready[k]));
        checkOutput("tx_start", k, 32'(tx_start[k]), 32'(e_start[k]));
        checkOutput("tx_byte", k, 32'(tx_byte[k]), 32'(e_byte[k]));
        checkOutput("rx_word_valid", k, 32'(rx_word_valid[k]), 32'(e_rvalid[k]));
        checkOutput("rx_word", k, rx_word[k], e_rword[k]);
        checkOutput("rx_overrun", k, 32'(rx_overrun[k]), 32'(e_ovr[k]));
        checkOutput("rx_timeout", k, 32'(rx_timeout[k]), 32'(e_tmo[k]));
      end
    end
  end

  // Transmitter stand-in: answers each tx_start with tx_done 1..5 cycles later, optional stray pulses.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      tx_done[k] = 1'b0;
      if (tx_start[k] === 1'b1) begin
        if (k == 0) cap0.push_back(tx_byte[k]);
        else cap1.push_back(tx_byte[k]);
        dcount[k] = $urandom_range(1, 5);
      end else if (dcount[k] > 0) begin
        dcount[k]--;
        if (dcount[k] == 0) tx_done[k] = 1'b1;
      end else if (stray_en && $urandom_range(0, 15) == 0) begin
        tx_done[k] = 1'b1;
      end
      if (rx_overrun[k] === 1'b1) ovr_seen[k]++;
      if (rx_timeout[k] === 1'b1) tmo_seen[k]++;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic bv,
                               input logic [7:0] b, input logic rdy);
    tx_word_valid = v;
    tx_word       = w;
    rx_byte_valid = bv;
    rx_byte       = b;
    rx_word_ready = rdy;
    stepCycle();
  endtask

  task automatic idle(int n);
    repeat (n) applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic applyReset(int n);
    rst_n = 1'b0;
    dcount[0] = 0;
    dcount[1] = 0;
    idle(n);
    rst_n = 1'b1;
  endtask

  task automatic waitTxIdle(string name, int limit);
    int n;
    n = 0;
    while (!(tx_word_ready[0] === 1'b1 && tx_word_ready[1] === 1'b1) && n < limit) begin
      idle(1);
      n++;
    end
    checkOutput({name, "_tx_finished"}, 0, 32'(n < limit), 32'd1);
  endtask

  task automatic clearSeen();
    for (int k = 0; k < 2; k++) begin
      ovr_seen[k] = 0;
      tmo_seen[k] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int quiet;
    logic bv;
    rst_n = 1'b0;
    tx_word_valid = 1'b0; tx_word = '0; rx_byte_valid = 1'b0; rx_byte = '0; rx_word_ready = 1'b0;
    tx_done[0] = 1'b0; tx_done[1] = 1'b0;
    dcount[0] = 0; dcount[1] = 0;
    clearSeen();
    applyReset(3);
    checkOutput("reset_tx_word_ready", 0, 32'(tx_word_ready[0]), 32'd1);
    checkOutput("reset_rx_word", 0, rx_word[0], 32'h0);

    // T1: LSB-first byte order on both widths
    cap0.delete(); cap1.delete();
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b0, 8'h00, 1'b0);
    waitTxIdle("t1", 200);
    checkOutput("t1_count", 0, 32'(cap0.size()), 32'd4);
    checkOutput("t1_count", 1, 32'(cap1.size()), 32'd3);
    for (int i = 0; i < 4; i++) if (i < cap0.size()) checkOutput("t1_byte", 0, 32'(cap0[i]), 32'(t1_exp[i]));
    for (int i = 0; i < 3; i++) if (i < cap1.size()) checkOutput("t1_byte", 1, 32'(cap1[i]), 32'(t1_exp[i]));

    // T3: assemble, hold with ready low, overrun
    clearSeen();
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h11, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h22, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h44, 1'b0);
    idle(3);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h99, 1'b0);
    idle(6);
    checkOutput("t3_word", 0, rx_word[0], 32'h44332211);
    checkOutput("t3_word", 1, rx_word[1], 32'h00332211);
    checkOutput("t3_valid", 0, 32'(rx_word_valid[0]), 32'd1);
    checkOutput("t3_overruns", 0, 32'(ovr_seen[0]), 32'd1);
    checkOutput("t3_overruns", 1, 32'(ovr_seen[1]), 32'd2);

    // T4: handshake and new byte0 in the same cycle
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h55, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h66, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h77, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h88, 1'b0);
    idle(1);
    checkOutput("t4_word", 0, rx_word[0], 32'h88776655);
    checkOutput("t4_word", 1, rx_word[1], 32'h00776655);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // T5: partial word timeout, then a byte landing exactly on the timeout cycle
    clearSeen();
    applyStimulus(1'b0, 32'h0, 1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'hBB, 1'b0);
    idle(25);
    checkOutput("t5_timeouts", 0, 32'(tmo_seen[0]), TMO_EN ? 32'd1 : 32'd0);
    checkOutput("t5_timeouts", 1, 32'(tmo_seen[1]), TMO_EN ? 32'd1 : 32'd0);
    if (!TMO_EN) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 8'hA5, 1'b0);
      applyStimulus(1'b0, 32'h0, 1'b1, 8'hB6, 1'b0);
      checkOutput("t5_held_partial", 0, rx_word[0], 32'hB6A5BBAA);
      applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
      idle(1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h03, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'h04, 1'b0);
    if (TMO_EN) checkOutput("t5_clean_word", 0, rx_word[0], 32'h04030201);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    idle(1);
    clearSeen();
    applyStimulus(1'b0, 32'h0, 1'b1, 8'hCC, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'hDD, 1'b0);
    idle(TMO - 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'hEE, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 8'hFF, 1'b0);
    checkOutput("t5_no_timeout", 0, 32'(tmo_seen[0]), 32'd0);
    checkOutput("t5_edge_word", 0, rx_word[0], 32'hFFEEDDCC);
    checkOutput("t5_edge_word", 1, rx_word[1], 32'h00EEDDCC);
    applyStimulus(1'b0, 32'h0, 1'b0, 8'h00, 1'b1);
    idle(1);

    // T6: reset mid-word on both paths
    cap0.delete();
    applyStimulus(1'b1, 32'h0BADF00D, 1'b1, 8'h5A, 1'b0);
    n = 0;
    while (cap0.size() < 2 && n < 100) begin
      idle(1);
      n++;
    end
    checkOutput("t6_reached_byte2", 0, 32'(cap0.size()), 32'd2);
    idle(1);
    applyReset(1);
    checkOutput("t6_ready", 0, 32'(tx_word_ready[0]), 32'd1);
    checkOutput("t6_start", 0, 32'(tx_start[0]), 32'd0);
    checkOutput("t6_rx_word", 0, rx_word[0], 32'h0);
    cap0.delete();
    applyStimulus(1'b1, 32'h12345678, 1'b0, 8'h00, 1'b0);
    waitTxIdle("t6", 200);
    checkOutput("t6_count", 0, 32'(cap0.size()), 32'd4);
    for (int i = 0; i < 4; i++) if (i < cap0.size()) checkOutput("t6_byte", 0, 32'(cap0[i]), 32'(t6_exp[i]));

    // Randomized traffic with stray tx_done, silence bursts and occasional resets
    stray_en = 1'b1;
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        applyReset($urandom_range(1, 3));
      end else begin
        if (quiet > 0) begin
          quiet--;
          bv = 1'b0;
        end else begin
          bv = ($urandom_range(0, 2) == 0);
          if ($urandom_range(0, 40) == 0) quiet = $urandom_range(TMO - 3, TMO + 8);
        end
        applyStimulus($urandom_range(0, 3) == 0, $urandom, bv, 8'($urandom_range(0, 255)),
                      $urandom_range(0, 2) == 0);
      end
    end
    stray_en = 1'b0;
    idle(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
